// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Parity/baud codes match the UART core's encoding.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_EVEN  = 2'b10,
      PAR_NONE2 = 2'b11
   } parity_e;

   typedef enum logic [1:0] {
      BAUD_2400  = 2'b00,
      BAUD_4800  = 2'b01,
      BAUD_9600  = 2'b10,
      BAUD_19200 = 2'b11
   } baud_e;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_START     = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4
   } state_e;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] parity;
      logic [1:0] baud;
   } frame_cfg_t;

   localparam int DEF_N_REQ          = 4;
   localparam int DEF_TIMEOUT_CYCLES = 300000;
   localparam int DEF_GAP_CYCLES     = 16;
   localparam int DEF_CNT_W          = 20;

   function automatic logic [2:0] rr_next(
      input logic [2:0] idx,
      input int         n
   );
      if (int'(idx) + 1 >= n) return 3'd0;
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above
// rr_ptr, wrapping to 0.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       rr_ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [2:0]       gnt_idx,
   output logic             gnt_any
);

   always_comb begin
      int c;
      c       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         c = int'(rr_ptr) + i;
         if (c >= N_REQ) c = c - N_REQ;
         if (!gnt_any && req[c]) begin
            gnt_any = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = 3'(c);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit path among
// N_REQ requesters, with watchdog and inter-frame gap.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int N_REQ          = DEF_N_REQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [2*N_REQ-1:0]   req_parity,
   input  logic [2*N_REQ-1:0]   req_baud,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     done,
   output logic                 timeout_err,
   output logic                 busy,
   output logic [2:0]           owner,
   output logic                 send,
   output logic [7:0]           data_in,
   output logic [1:0]           parity_type,
   output logic [1:0]           baud_rate,
   input  logic                 tx_active_flag,
   input  logic                 tx_done_flag
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         rr_ptr_q, rr_ptr_d;
   logic [2:0]         owner_q, owner_d;
   frame_cfg_t         cfg_q, cfg_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic               tmo_q, tmo_d;
   logic               busy_q, busy_d;
   logic               send_q, send_d;
   logic               txd_prev_q;

   logic [N_REQ-1:0]   arb_gnt;
   logic [2:0]         arb_idx;
   logic               arb_any;
   logic               completion;
   logic               expired;

   rr_arbiter #(
      .N_REQ   (N_REQ)
   ) u_arb (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   // A done level in START means a frame shorter than our reaction time
   assign completion =
      (state_q == S_START && tx_done_flag) ||
      (state_q == S_WAIT_DONE && tx_done_flag && !txd_prev_q);

   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      cfg_d    = cfg_q;
      grant_d  = '0;
      done_d   = '0;
      tmo_d    = 1'b0;
      busy_d   = busy_q;
      send_d   = send_q;
      unique case (state_q)
         S_IDLE: begin
            if (arb_any) begin
               owner_d      = arb_idx;
               grant_d      = arb_gnt;
               cfg_d.data   = req_data[8*arb_idx +: 8];
               cfg_d.parity = req_parity[2*arb_idx +: 2];
               cfg_d.baud   = req_baud[2*arb_idx +: 2];
               busy_d       = 1'b1;
               state_d      = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            send_d  = 1'b1;
            state_d = S_START;
         end
         S_START, S_WAIT_DONE: begin
            cnt_d = cnt_q + 1'b1;
            if (completion) begin
               done_d[owner_q] = 1'b1;
               send_d          = 1'b0;
               cnt_d           = '0;
               state_d         = S_GAP;
            end else if (expired) begin
               tmo_d   = 1'b1;
               send_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_GAP;
            end else if (state_q == S_START && tx_active_flag) begin
               send_d  = 1'b0;
               state_d = S_WAIT_DONE;
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
               rr_ptr_d = rr_next(owner_q, N_REQ);
               busy_d   = 1'b0;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         cfg_q      <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         tmo_q      <= 1'b0;
         busy_q     <= 1'b0;
         send_q     <= 1'b0;
         txd_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         cfg_q      <= cfg_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
         busy_q     <= busy_d;
         send_q     <= send_d;
         txd_prev_q <= tx_done_flag;
      end
   end

   assign grant       = grant_q;
   assign done        = done_q;
   assign timeout_err = tmo_q;
   assign busy        = busy_q;
   assign owner       = owner_q;
   assign send        = send_q;
   assign data_in     = cfg_q.data;
   assign parity_type = cfg_q.parity;
   assign baud_rate   = cfg_q.baud;

endmodule
